// File: rtl/reaction_timer_ctrl.sv
// Reaction-time trial controller: random pre-stimulus delay, then measures the
// user's response in milliseconds, flagging false starts and timeouts.
module reaction_timer_ctrl #(
  parameter int          CLKS_PER_MS  = 100000,
  parameter int          MIN_DELAY_MS = 2000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic       stim_led,
  output logic [9:0] ms_count,
  output logic [2:0] state,
  output logic       result_valid,
  output logic       early,
  output logic       timeout,
  output logic       fin_pulse
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_ARMED   = 3'd2,
    S_DONE    = 3'd3,
    S_EARLY   = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  localparam int          PW        = $clog2(CLKS_PER_MS);
  localparam logic [PW-1:0] PRESC_TC = PW'(CLKS_PER_MS - 1);
  localparam logic [15:0] MIN_DELAY = 16'(MIN_DELAY_MS);
  localparam logic [9:0]  MS_MAX    = 10'd999;

  state_t        state_r;
  state_t        state_next_s;
  logic [PW-1:0] presc_r;
  logic          ms_tick_s;
  logic [15:0]   lfsr_r;
  logic [15:0]   delay_ms_r;
  logic [15:0]   delay_cnt_r;
  logic [9:0]    ms_count_r;
  logic [9:0]    ms_next_s;
  logic          load_delay_s;
  logic          stim_led_r;
  logic          result_valid_r;
  logic          early_r;
  logic          timeout_r;
  logic          fin_pulse_r;

  // Taps 16,14,13,11 in right-shift form; a zero result reloads the seed.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic        fb;
    logic [15:0] nxt;
    fb  = v[0] ^ v[2] ^ v[3] ^ v[5];
    nxt = {fb, v[15:1]};
    if (nxt == 16'd0) begin
      nxt = LFSR_SEED;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  assign ms_tick_s = (presc_r == PRESC_TC);

  // Next-state and next ms_count; clear outranks every other input.
  always_comb begin
    state_next_s = state_r;
    ms_next_s    = ms_count_r;
    load_delay_s = 1'b0;
    if (clear) begin
      state_next_s = S_IDLE;
      ms_next_s    = 10'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          ms_next_s = 10'd0;
          if (start) begin
            state_next_s = S_WAIT;
            load_delay_s = 1'b1;
          end else begin
            state_next_s = S_IDLE;
          end
        end
        S_WAIT: begin
          ms_next_s = 10'd0;
          if (stop) begin
            state_next_s = S_EARLY;
          end else if (delay_cnt_r == delay_ms_r) begin
            state_next_s = S_ARMED;
          end else begin
            state_next_s = S_WAIT;
          end
        end
        S_ARMED: begin
          if (stop) begin
            state_next_s = S_DONE;
          end else if (ms_tick_s) begin
            if (ms_count_r == MS_MAX) begin
              state_next_s = S_TIMEOUT;
            end else begin
              ms_next_s = ms_count_r + 10'd1;
            end
          end else begin
            state_next_s = S_ARMED;
          end
        end
        S_DONE, S_EARLY, S_TIMEOUT: begin
          if (start) begin
            state_next_s = S_WAIT;
            load_delay_s = 1'b1;
            ms_next_s    = 10'd0;
          end else begin
            state_next_s = state_r;
          end
        end
        default: begin
          state_next_s = S_IDLE;
          ms_next_s    = 10'd0;
        end
      endcase
    end
  end

  // State, result count and LFSR registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      ms_count_r <= 10'd0;
      lfsr_r     <= LFSR_SEED;
    end else begin
      state_r    <= state_next_s;
      ms_count_r <= ms_next_s;
      lfsr_r     <= lfsr_next(lfsr_r);
    end
  end

  // Millisecond prescaler, restarted on every state change so each phase
  // begins on a whole-millisecond boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r <= '0;
    end else if ((state_next_s != state_r) || ms_tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Pre-stimulus delay target and elapsed-ms counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay_ms_r  <= 16'd0;
      delay_cnt_r <= 16'd0;
    end else if (load_delay_s) begin
      delay_ms_r  <= MIN_DELAY + {5'd0, lfsr_r[10:0]};
      delay_cnt_r <= 16'd0;
    end else if ((state_r == S_WAIT) && ms_tick_s) begin
      delay_cnt_r <= delay_cnt_r + 16'd1;
    end
  end

  // Status flags decoded from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stim_led_r     <= 1'b0;
      result_valid_r <= 1'b0;
      early_r        <= 1'b0;
      timeout_r      <= 1'b0;
      fin_pulse_r    <= 1'b0;
    end else begin
      stim_led_r     <= (state_next_s == S_ARMED);
      result_valid_r <= (state_next_s == S_DONE);
      early_r        <= (state_next_s == S_EARLY);
      timeout_r      <= (state_next_s == S_TIMEOUT);
      fin_pulse_r    <= (state_next_s != state_r) &&
                        ((state_next_s == S_DONE) || (state_next_s == S_EARLY) ||
                         (state_next_s == S_TIMEOUT));
    end
  end

  assign state        = state_r;
  assign ms_count     = ms_count_r;
  assign stim_led     = stim_led_r;
  assign result_valid = result_valid_r;
  assign early        = early_r;
  assign timeout      = timeout_r;
  assign fin_pulse    = fin_pulse_r;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl: per-cycle vector table plus
// multi-cycle trial sequences (normal, restart, reset, timeout, priority).
module tb_reaction_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       stim_led;
  logic [9:0] ms_count;
  logic [2:0] state;
  logic       result_valid;
  logic       early;
  logic       timeout;
  logic       fin_pulse;

  int compared   = 0;
  int mismatched = 0;
  int stim_bad   = 0;
  int fin_cnt    = 0;

  logic [15:0] m_lfsr;

  reaction_timer_ctrl #(.CLKS_PER_MS(4), .MIN_DELAY_MS(3), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .stim_led(stim_led), .ms_count(ms_count), .state(state),
    .result_valid(result_valid), .early(early), .timeout(timeout),
    .fin_pulse(fin_pulse)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  always @(negedge clk) begin
    if (rst && stim_led && state != 3'd2) stim_bad++;
    if (rst && fin_pulse) fin_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       st, sp, cl;
    logic [2:0] e_state;
    logic       e_stim;
    logic [9:0] e_ms;
    logic       e_rv, e_early, e_to, e_fin;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input int st, input int stim, input int ms,
                         input int rv, input int er, input int to, input int fin);
    chk({tag, "_state"}, int'(state), st);
    chk({tag, "_stim"}, int'(stim_led), stim);
    chk({tag, "_ms"}, int'(ms_count), ms);
    chk({tag, "_rv"}, int'(result_valid), rv);
    chk({tag, "_early"}, int'(early), er);
    chk({tag, "_timeout"}, int'(timeout), to);
    chk({tag, "_fin"}, int'(fin_pulse), fin);
  endtask

  task automatic start_trial(input string tag, output int exp_d);
    exp_d = 3 + int'(m_lfsr[10:0]);
    start = 1'b1;
    tick_cyc();
    start = 1'b0;
    chk_all({tag, "_start"}, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at the first WAIT sample; returns at the first ARMED sample.
  task automatic measure_wait(input string tag, input int exp_d);
    int n = 0;
    while (state == 3'd1 && n < 9000) begin
      n++;
      tick_cyc();
    end
    chk({tag, "_wait_cycles"}, n, 4 * exp_d + 1);
    chk({tag, "_delay_in_range"}, int'(((n - 1) / 4 >= 3) && ((n - 1) / 4 <= 2050)), 1);
    chk_all({tag, "_armed"}, 2, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int d;
    int n;
    int bad;
    int f0;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    #3;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      start = vecs[i].st;
      stop  = vecs[i].sp;
      clear = vecs[i].cl;
      tick_cyc();
      start = 1'b0;
      stop  = 1'b0;
      clear = 1'b0;
      chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_stim, vecs[i].e_ms,
              vecs[i].e_rv, vecs[i].e_early, vecs[i].e_to, vecs[i].e_fin);
    end

    // Normal trial: stop after 37 ms.
    start_trial("norm", d);
    measure_wait("norm", d);
    repeat (148) tick_cyc();
    chk("norm_ms37", int'(ms_count), 37);
    f0 = fin_cnt;
    stop = 1'b1;
    tick_cyc();
    stop = 1'b0;
    chk_all("norm_done", 3, 0, 37, 1, 0, 0, 1);
    bad = 0;
    stop = 1'b1;
    repeat (10) begin
      tick_cyc();
      if (state != 3'd3 || ms_count != 10'd37 || fin_pulse) bad++;
    end
    stop = 1'b0;
    chk("norm_hold", bad, 0);
    chk("norm_fin_once", fin_cnt - f0, 1);

    // Restart from DONE; stop coincident with a ms tick must not increment.
    start_trial("rest", d);
    measure_wait("rest", d);
    repeat (20) tick_cyc();
    chk("rest_ms5", int'(ms_count), 5);
    repeat (3) tick_cyc();
    chk("rest_ms5_pre_tick", int'(ms_count), 5);
    stop = 1'b1;
    tick_cyc();
    stop = 1'b0;
    chk_all("rest_done", 3, 0, 5, 1, 0, 0, 1);

    // Reset mid-WAIT: outputs clear before the next clock edge.
    start_trial("rw", d);
    repeat (5) tick_cyc();
    f0 = fin_cnt;
    #1 rst = 1'b0;
    #1;
    chk_all("rw_async", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) tick_cyc();
    chk_all("rw_idle", 0, 0, 0, 0, 0, 0, 0);
    chk("rw_no_fin", fin_cnt - f0, 0);

    // Timeout: no stop.
    start_trial("to", d);
    measure_wait("to", d);
    n = 0;
    while (state == 3'd2 && n < 5000) begin
      n++;
      tick_cyc();
    end
    chk("to_armed_cycles", n, 4000);
    chk_all("to_hit", 5, 0, 999, 0, 0, 1, 1);
    bad = 0;
    repeat (400) begin
      tick_cyc();
      if (state != 3'd5 || ms_count != 10'd999 || !timeout || fin_pulse) bad++;
    end
    chk("to_hold", bad, 0);

    // Clear and stop together in ARMED: clear wins, no result.
    start_trial("pri", d);
    measure_wait("pri", d);
    repeat (10) tick_cyc();
    chk("pri_ms2", int'(ms_count), 2);
    f0 = fin_cnt;
    clear = 1'b1;
    stop  = 1'b1;
    tick_cyc();
    clear = 1'b0;
    stop  = 1'b0;
    chk_all("pri_clear", 0, 0, 0, 0, 0, 0, 0);
    chk("pri_no_fin", fin_cnt - f0, 0);

    chk("stim_only_armed", stim_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reaction_timer_ctrl.md
REACTION_TIMER_CTRL -- requirements
Module: reaction_timer_ctrl

Interface
REQ-001 Parameter CLKS_PER_MS, default 100000: clk cycles per 1 ms tick; must be >= 2.
REQ-002 Parameter MIN_DELAY_MS, default 2000: minimum random pre-stimulus delay in ms.
REQ-003 Parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-004 clk  in  1  single system clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse, already debounced: begin a trial.
REQ-007 stop  in  1  single-cycle pulse, already debounced: user reaction.
REQ-008 clear  in  1  single-cycle pulse: abort or acknowledge, then return to IDLE.
REQ-009 stim_led  out  1  stimulus indicator; 1 only in ARMED.
REQ-010 ms_count  out  10  reaction time in ms (0..999), binary; feeds the BCD converter.
REQ-011 state  out  3  encoding: IDLE=0, WAIT=1, ARMED=2, DONE=3, EARLY=4, TIMEOUT=5.
REQ-012 result_valid  out  1  1 while in DONE.
REQ-013 early  out  1  1 while in EARLY.
REQ-014 timeout  out  1  1 while in TIMEOUT.
REQ-015 fin_pulse  out  1  one-cycle pulse on the first cycle in DONE, EARLY or TIMEOUT.

Function
REQ-016 Prescaler: counts 0..CLKS_PER_MS-1 and asserts internal ms_tick for one cycle at terminal count; it shall clear to 0 on every state change.
REQ-017 LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every cycle in all states.
REQ-018 LFSR: shall never reach zero.
REQ-019 IDLE: stim_led=0, ms_count=0; start -> WAIT.
REQ-020 IDLE -> WAIT: delay_ms latched as MIN_DELAY_MS + lfsr[10:0], range MIN..MIN+2047; delay counter zeroed.
REQ-021 WAIT: delay counter increments on each ms_tick.
REQ-022 WAIT: stop -> EARLY; ms_count stays 0.
REQ-023 WAIT: when delay counter equals delay_ms -> ARMED.
REQ-024 WAIT: stop and delay expiry in the same cycle -> EARLY.
REQ-025 ARMED: stim_led=1 from the first ARMED cycle; ms_count starts at 0 and increments by 1 per ms_tick.
REQ-026 ARMED: stop -> DONE with ms_count frozen at its current value.
REQ-027 ARMED: stop coincident with ms_tick -> no increment.
REQ-028 ARMED: ms_tick while ms_count==999 -> TIMEOUT, ms_count held at 999.
REQ-029 ARMED: ms_count shall never wrap.
REQ-030 DONE/EARLY/TIMEOUT: hold ms_count and flags; start -> WAIT with a new delay latched; ms_count -> 0.
REQ-031 clear in any state -> IDLE on the next edge, ms_count=0.
REQ-032 clear has priority over start and stop in the same cycle.
REQ-033 start while in WAIT or ARMED shall be ignored.
REQ-034 stop in IDLE, DONE, EARLY or TIMEOUT shall be ignored.
REQ-035 All outputs shall be registered, with no combinational path from inputs to outputs.
REQ-036 State transitions take effect one clk after the triggering input sample.

Reset
REQ-037 rst low -> immediately, without waiting for clk: state=IDLE; stim_led, result_valid, early, timeout, fin_pulse=0; ms_count=0; prescaler and delay counter=0; LFSR=LFSR_SEED.
REQ-038 Reset asserted mid-trial (WAIT or ARMED) shall abort with no fin_pulse.
REQ-039 After rst rises, the block stays in IDLE until start.

Verification (CLKS_PER_MS=4, MIN_DELAY_MS=3 for simulation)
REQ-040 Normal trial: start, wait for stim_led, stop after 37 ticks -> state=3, ms_count=37, result_valid=1, one fin_pulse.
REQ-041 False start: start, then stop 1 tick later -> state=4, early=1, ms_count=0, stim_led never 1.
REQ-042 Timeout: start, no stop -> ms_count reaches 999, state=5, timeout=1, ms_count held 999 for 100 further ticks.
REQ-043 Priority: in ARMED, drive clear and stop in the same cycle -> state=0, ms_count=0, no fin_pulse.
REQ-044 Restart and reset: in DONE, pulse start -> state=1, ms_count=0, new delay within 3..2050 ms; then assert rst mid-WAIT -> IDLE with all outputs 0 before the next clk edge.
